// File: rtl/alu_pkg.sv
// Shared encodings for the ALU pipeline: operation codes and controller states.
package alu_pkg;

   typedef enum logic [3:0] {
      OpAdd  = 4'd0,
      OpSub  = 4'd1,
      OpMul  = 4'd2,
      OpDiv  = 4'd3,
      OpMod  = 4'd4,
      OpAnd  = 4'd5,
      OpOr   = 4'd6,
      OpXor  = 4'd7,
      OpNand = 4'd8,
      OpNor  = 4'd9,
      OpXnor = 4'd10,
      OpNot  = 4'd11,
      OpShl  = 4'd12,
      OpShr  = 4'd13,
      OpSra  = 4'd14,
      OpSlt  = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_e;

   function automatic logic is_muldiv(input op_e o);
      return o inside {OpMul, OpDiv, OpMod};
   endfunction

   function automatic logic is_divide(input op_e o);
      return o inside {OpDiv, OpMod};
   endfunction

endpackage

// File: rtl/alu_pipe_muldiv.sv
// Iterative WIDTH-step datapath: shift-add multiply or restoring divide on one shared register pair.
module alu_pipe_muldiv #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = $clog2(WIDTH);

   logic             busy_q, div_q;
   logic [CntW-1:0]  cnt_q;
   logic [WIDTH-1:0] hi_q, lo_q, b_q;
   logic [WIDTH-1:0] hi_d, lo_d, diff;
   logic [WIDTH:0]   sum, shifted;
   logic             ge;

   always_comb begin
      sum     = '0;
      shifted = '0;
      diff    = '0;
      ge      = 1'b0;
      if (div_q) begin
         shifted = {hi_q, lo_q[WIDTH-1]};
         ge      = shifted >= {1'b0, b_q};
         // When ge holds the true difference is below b, so WIDTH bits suffice.
         diff    = shifted[WIDTH-1:0] - b_q;
         hi_d    = ge ? diff : shifted[WIDTH-1:0];
         lo_d    = {lo_q[WIDTH-2:0], ge};
      end else begin
         sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
         hi_d = sum[WIDTH:1];
         lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // Results are the values being written on the final step, so the top can capture them together.
   assign done = busy_q && (cnt_q == CntW'(WIDTH - 1));
   assign hi   = hi_d;
   assign lo   = lo_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         b_q    <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         div_q  <= is_div;
         cnt_q  <= '0;
         hi_q   <= '0;
         lo_q   <= a;
         b_q    <= b;
      end else if (busy_q) begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_q + 1'b1;
         if (done) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative mul/div/mod, results held until consumed.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic [WIDTH-1:0] res_hi,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_dz
);

   state_e           state_q, state_d;
   op_e              op_in, op_q;
   logic             accept, go_iter, md_is_div, md_done, big_shift, load;
   logic [WIDTH-1:0] md_hi, md_lo;
   logic [WIDTH:0]   add_full;
   logic [WIDTH-1:0] sc_res, sc_hi;
   logic             sc_c, sc_v, sc_dz;
   logic [WIDTH-1:0] res_q, res_hi_q, res_d, res_hi_d;
   logic             z_q, c_q, v_q, dz_q, z_d, c_d, v_d, dz_d;

   assign op_in     = op_e'(op);
   assign in_ready  = (state_q == StIdle);
   assign accept    = in_valid && in_ready;
   assign md_is_div = is_divide(op_in);
   // Division by zero is answered immediately by the single-cycle path.
   assign go_iter   = accept && is_muldiv(op_in) && !(md_is_div && (b == '0));
   assign big_shift = (b >= WIDTH'(WIDTH));

   alu_pipe_muldiv #(
      .WIDTH(WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (go_iter),
      .is_div (md_is_div),
      .a      (a),
      .b      (b),
      .done   (md_done),
      .hi     (md_hi),
      .lo     (md_lo)
   );

   always_comb begin
      sc_res   = '0;
      sc_hi    = '0;
      sc_c     = 1'b0;
      sc_v     = 1'b0;
      sc_dz    = 1'b0;
      add_full = '0;
      unique case (op_in)
         OpAdd: begin
            add_full = {1'b0, a} + {1'b0, b};
            sc_res   = add_full[WIDTH-1:0];
            sc_c     = add_full[WIDTH];
            sc_v     = (a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
         end
         OpSub: begin
            sc_res = a - b;
            sc_c   = a < b;
            sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
         end
         OpMul:        sc_res = '0;
         OpDiv, OpMod: begin
            sc_res = '1;
            sc_hi  = a;
            sc_dz  = 1'b1;
         end
         OpAnd:  sc_res = a & b;
         OpOr:   sc_res = a | b;
         OpXor:  sc_res = a ^ b;
         OpNand: sc_res = ~(a & b);
         OpNor:  sc_res = ~(a | b);
         OpXnor: sc_res = ~(a ^ b);
         OpNot:  sc_res = ~a;
         OpShl:  sc_res = big_shift ? '0 : (a << b);
         OpShr:  sc_res = big_shift ? '0 : (a >> b);
         OpSra:  sc_res = big_shift ? {WIDTH{a[WIDTH-1]}} : ($signed(a) >>> b);
         OpSlt:  sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      endcase
   end

   always_comb begin
      load     = 1'b0;
      res_d    = res_q;
      res_hi_d = res_hi_q;
      c_d      = c_q;
      v_d      = v_q;
      dz_d     = dz_q;
      if (accept && !go_iter) begin
         load     = 1'b1;
         res_d    = sc_res;
         res_hi_d = sc_hi;
         c_d      = sc_c;
         v_d      = sc_v;
         dz_d     = sc_dz;
      end else if ((state_q == StBusy) && md_done) begin
         load     = 1'b1;
         c_d      = 1'b0;
         v_d      = 1'b0;
         dz_d     = 1'b0;
         res_d    = md_lo;
         res_hi_d = md_hi;
         if (op_q == OpMod) begin
            res_d    = md_hi;
            res_hi_d = md_lo;
         end else if (op_q == OpMul) begin
            v_d = (md_hi != '0);
         end
      end
      z_d = (res_d == '0);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = go_iter ? StBusy : StDone;
         StBusy:  if (md_done) state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         op_q     <= OpAdd;
         res_q    <= '0;
         res_hi_q <= '0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q <= op_in;
         end
         if (load) begin
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
            dz_q     <= dz_d;
         end
      end
   end

   assign out_valid = (state_q == StDone);
   assign res       = res_q;
   assign res_hi    = res_hi_q;
   assign flag_z    = z_q;
   assign flag_c    = c_q;
   assign flag_v    = v_q;
   assign flag_dz   = dz_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed bench for alu_pipe against an arithmetic reference model.
module tb_alu_pipe;

   localparam int W = 8;
   localparam int MaxLat = 50;

   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         z;
      logic         c;
      logic         v;
      logic         dz;
   } rec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   op = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] res, res_hi;
   logic         flag_z, flag_c, flag_v, flag_dz;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_pipe #(
      .WIDTH(W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .res_hi    (res_hi),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .flag_v    (flag_v),
      .flag_dz   (flag_dz)
   );

   function automatic rec_t outs();
      rec_t r;
      r.res = res;
      r.hi  = res_hi;
      r.z   = flag_z;
      r.c   = flag_c;
      r.v   = flag_v;
      r.dz  = flag_dz;
      return r;
   endfunction

   // Reference: plain wide-integer arithmetic, truncated to W bits.
   function automatic rec_t model(input int o, input logic [W-1:0] x, input logic [W-1:0] y);
      rec_t   m;
      longint ux, uy, sx, sy, r, s, p;
      longint smax, smin, full;
      m    = '0;
      ux   = longint'(x);
      uy   = longint'(y);
      sx   = longint'($signed(x));
      sy   = longint'($signed(y));
      smax = (64'sd1 <<< (W - 1)) - 1;
      smin = -(64'sd1 <<< (W - 1));
      full = (64'sd1 <<< W);
      case (o)
         0: begin
            r = ux + uy; m.res = r[W-1:0]; m.c = (r >= full);
            s = sx + sy; m.v = (s > smax) || (s < smin);
         end
         1: begin
            r = ux - uy; m.res = r[W-1:0]; m.c = (ux < uy);
            s = sx - sy; m.v = (s > smax) || (s < smin);
         end
         2: begin
            p = ux * uy; m.res = p[W-1:0]; m.hi = p[2*W-1:W]; m.v = (m.hi != 0);
         end
         3, 4: begin
            if (uy == 0) begin
               m.res = '1; m.hi = x; m.dz = 1'b1;
            end else begin
               r = ux / uy; s = ux % uy;
               m.res = (o == 3) ? r[W-1:0] : s[W-1:0];
               m.hi  = (o == 3) ? s[W-1:0] : r[W-1:0];
            end
         end
         5:  m.res = x & y;
         6:  m.res = x | y;
         7:  m.res = x ^ y;
         8:  m.res = ~(x & y);
         9:  m.res = ~(x | y);
         10: m.res = ~(x ^ y);
         11: m.res = ~x;
         12: begin r = (uy >= W) ? 0 : (ux << uy); m.res = r[W-1:0]; end
         13: begin r = (uy >= W) ? 0 : (ux >> uy); m.res = r[W-1:0]; end
         14: begin
            if (uy >= W) r = (sx < 0) ? -1 : 0;
            else r = sx >>> uy;
            m.res = r[W-1:0];
         end
         default: m.res = (ux < uy) ? 1 : 0;
      endcase
      m.z = (m.res == 0);
      return m;
   endfunction

   function automatic int model_lat(input int o, input logic [W-1:0] y);
      if (o == 2 || ((o == 3 || o == 4) && y != 0)) return W + 1;
      return 1;
   endfunction

   // One full transaction: present, accept, wait (bounded) for result, retire.
   task automatic run_op(input int o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output rec_t got);
      @(negedge clk);
      in_valid  = 1'b1;
      op        = 4'(o);
      a         = x;
      b         = y;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < MaxLat) begin
         @(posedge clk); #1;
         lat++;
      end
      got = outs();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rec_t got;
      #2;
      got = outs();
      tests++;
      if (got !== rec_t'(0) || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: got out_valid=%b outs=%h, want 0 / %h", out_valid, got, rec_t'(0));
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_add_carry();
      rec_t got, exp;
      int   lat;
      run_op(0, 8'hFF, 8'h01, lat, got);
      exp = '{res: 8'h00, hi: 8'h00, z: 1'b1, c: 1'b1, v: 1'b0, dz: 1'b0};
      tests++;
      if (lat !== 1) begin
         fails++;
         $display("FAIL add_latency: got %0d want 1", lat);
      end
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL add_carry: got %h want %h", got, exp);
      end
   endtask

   task automatic test_mul();
      rec_t got, exp;
      int   lat;
      run_op(2, 8'd200, 8'd3, lat, got);
      exp = '{res: 8'h58, hi: 8'h02, z: 1'b0, c: 1'b0, v: 1'b1, dz: 1'b0};
      tests++;
      if (lat !== W + 1) begin
         fails++;
         $display("FAIL mul_latency: got %0d want %0d", lat, W + 1);
      end
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL mul_result: got %h want %h", got, exp);
      end
   endtask

   task automatic test_div();
      rec_t got, exp;
      int   lat;
      run_op(3, 8'd100, 8'd7, lat, got);
      exp = '{res: 8'd14, hi: 8'd2, z: 1'b0, c: 1'b0, v: 1'b0, dz: 1'b0};
      tests++;
      if (lat !== W + 1 || got !== exp) begin
         fails++;
         $display("FAIL div_result: got lat=%0d %h want lat=%0d %h", lat, got, W + 1, exp);
      end
      run_op(3, 8'd100, 8'd0, lat, got);
      exp = '{res: 8'hFF, hi: 8'd100, z: 1'b0, c: 1'b0, v: 1'b0, dz: 1'b1};
      tests++;
      if (lat !== 1 || got !== exp) begin
         fails++;
         $display("FAIL div_by_zero: got lat=%0d %h want lat=1 %h", lat, got, exp);
      end
   endtask

   task automatic test_shifts();
      rec_t got;
      int   lat;
      run_op(14, 8'h80, 8'd9, lat, got);
      tests++;
      if (lat !== 1 || got.res !== 8'hFF || got.z !== 1'b0) begin
         fails++;
         $display("FAIL sra_big: got lat=%0d res=%h want lat=1 res=ff", lat, got.res);
      end
      run_op(12, 8'h81, 8'd1, lat, got);
      tests++;
      if (lat !== 1 || got.res !== 8'h02) begin
         fails++;
         $display("FAIL shl_1: got lat=%0d res=%h want lat=1 res=02", lat, got.res);
      end
   endtask

   task automatic test_reset_mid_mul();
      rec_t got;
      int   lat, seen;
      @(negedge clk);
      in_valid = 1'b1; op = 4'd2; a = 8'd201; b = 8'd77;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      got = outs();
      tests++;
      if (out_valid !== 1'b0 || got !== rec_t'(0)) begin
         fails++;
         $display("FAIL reset_async: got out_valid=%b outs=%h want 0 / 0", out_valid, got);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
      seen = 0;
      for (int i = 0; i < W + 3; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      tests++;
      if (seen !== 0) begin
         fails++;
         $display("FAIL reset_abandon: got %0d valid cycles want 0", seen);
      end
      run_op(0, 8'd2, 8'd3, lat, got);
      tests++;
      if (lat !== 1 || got.res !== 8'd5) begin
         fails++;
         $display("FAIL post_reset_add: got lat=%0d res=%0d want lat=1 res=5", lat, got.res);
      end
   endtask

   task automatic test_backpressure();
      rec_t got, exp;
      logic [W-1:0] x, y;
      int   lat, bad;
      x = W'($urandom_range(1, 255));
      y = W'($urandom_range(1, 255));
      exp = model(0, x, y);
      @(negedge clk);
      in_valid = 1'b1; op = 4'd0; a = x; b = y; out_ready = 1'b0;
      @(posedge clk); #1;
      // Keep offering a different request; it must be ignored while the result is held.
      op = 4'd7; a = ~x; b = 8'h5A;
      lat = 1;
      while (!out_valid && lat < MaxLat) begin
         @(posedge clk); #1;
         lat++;
      end
      got = outs();
      tests++;
      if (lat !== 1 || got !== exp) begin
         fails++;
         $display("FAIL bp_result: got lat=%0d %h want lat=1 %h", lat, got, exp);
      end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || outs() !== exp) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_retire: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_no_extra: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_random();
      rec_t got, exp;
      logic [W-1:0] x, y;
      int   o, lat, sel;
      for (int n = 0; n < 60; n++) begin
         o   = int'($urandom_range(0, 15));
         x   = W'($urandom);
         sel = int'($urandom_range(0, 5));
         if (sel == 0) y = '0;
         else if (sel == 1) y = W'($urandom_range(W, 255));
         else if (sel == 2) y = W'($urandom_range(0, W - 1));
         else y = W'($urandom);
         exp = model(o, x, y);
         run_op(o, x, y, lat, got);
         tests++;
         if (lat !== model_lat(o, y) || got !== exp) begin
            fails++;
            $display("FAIL random op=%0d a=%h b=%h: got lat=%0d %h want lat=%0d %h",
                     o, x, y, lat, got, model_lat(o, y), exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_carry();
      test_mul();
      test_div();
      test_shifts();
      test_reset_mid_mul();
      test_backpressure();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; legal range 4..32.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request carries a valid operation.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port op  input  4  operation select.
REQ-007 SHALL have ports a, b  input  WIDTH  operands, unsigned unless stated.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports res, res_hi  output  WIDTH  result low word, and high word (product upper half / remainder).
REQ-011 SHALL have ports flag_z, flag_c, flag_v, flag_dz  output  1  zero, carry/borrow, signed overflow, divide-by-zero.

Function
REQ-012 SHALL decode op: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 and, 6 or, 7 xor, 8 nand, 9 nor, 10 xnor, 11 not a, 12 shl, 13 shr logical, 14 sra, 15 slt unsigned (res=1 if a<b else 0).
REQ-013 SHALL use FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE.
REQ-014 SHALL accept a request on the cycle in_valid&in_ready, capturing op, a, b into registers.
REQ-015 SHALL, for single-cycle ops (all but 2,3,4), go IDLE->DONE and assert out_valid on the cycle after acceptance (latency 1).
REQ-016 SHALL, for ops 2/3/4 with nonzero divisor, go IDLE->BUSY, iterate exactly WIDTH cycles (shift-add multiply, restoring divide), then ->DONE; out_valid WIDTH+1 cycles after acceptance.
REQ-017 SHALL hold res, res_hi, flags, out_valid stable in DONE until out_valid&out_ready, then go ->IDLE on that edge.
REQ-018 SHALL not accept a new request while BUSY or DONE (no overlap, no result drop).
REQ-019 SHALL set res_hi=0 for all ops except mul (upper product half), div/mod (remainder).
REQ-020 SHALL for add/sub: res = WIDTH-bit truncation; flag_c = carry-out (add) or borrow (sub, a<b); flag_v = two's-complement overflow.
REQ-021 SHALL for mul: {res_hi,res}=a*b exactly; flag_v=1 iff res_hi!=0; flag_c=0.
REQ-022 SHALL for div: res=quotient, res_hi=remainder; for mod: res=remainder, res_hi=quotient.
REQ-023 SHALL on div/mod with b==0: skip BUSY (latency 1), res=all-ones, res_hi=a, flag_dz=1.
REQ-024 SHALL for shifts use amount b; if b>=WIDTH: shl/shr give 0, sra gives all copies of a[WIDTH-1].
REQ-025 SHALL set flag_z=1 iff res==0 for every op; flag_c, flag_v, flag_dz=0 where not defined above.

Reset
REQ-026 SHALL on rst_n low, immediately (asynchronously) force state=IDLE, out_valid=0, res=0, res_hi=0, all flags=0; in_ready=1 once rst_n high.
REQ-027 SHALL abandon any in-flight BUSY/DONE operation on reset; no result is emitted afterwards.

Structure
REQ-028 SHALL place op encoding constants and FSM state encoding in shared package alu_pkg.
REQ-029 SHALL implement the iterative multiply/divide datapath as sub-module alu_pipe_muldiv (start, done, WIDTH-parameterised); top holds FSM, handshake, single-cycle ops, flags.

Verification (WIDTH=8)
REQ-030 SHALL check add a=8'hFF b=8'h01 -> out_valid 1 cycle after accept, res=8'h00, flag_c=1, flag_z=1, flag_v=0.
REQ-031 SHALL check mul a=200 b=3 -> out_valid exactly 9 cycles after accept, res=8'h58, res_hi=8'h02, flag_v=1.
REQ-032 SHALL check div a=100 b=7 -> res=14, res_hi=2 after 9 cycles; div a=100 b=0 -> latency 1, res=8'hFF, res_hi=100, flag_dz=1.
REQ-033 SHALL check backpressure: out_ready held 0 for 5 cycles in DONE -> res/flags stable, in_ready=0, in_valid ignored; result retires on first out_ready=1.
REQ-034 SHALL check sra a=8'h80 b=9 -> res=8'hFF; shl a=8'h81 b=1 -> res=8'h02.
REQ-035 SHALL check reset mid-mul (rst_n low 3 cycles into BUSY) -> out_valid=0 immediately, in_ready=1 after release, next add 2+3 -> res=5.
